// File: rtl/phase_sequencer.sv
// Two-road intersection phase controller: green/yellow/all-red sequencing,
// pedestrian walk insertion and a night flashing-yellow mode, stepped by a 1 s tick.
module phase_sequencer #(
  parameter int T_GREEN1  = 25,
  parameter int T_GREEN2  = 20,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 8,
  parameter int T_PED_CUT = 5
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic [5:0] LEDS,
  output logic [5:0] cnt_r1,
  output logic [5:0] cnt_r2,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    G1    = 3'd0,
    Y1    = 3'd1,
    AR1   = 3'd2,
    G2    = 3'd3,
    Y2    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [5:0] D_GREEN1  = 6'(T_GREEN1);
  localparam logic [5:0] D_GREEN2  = 6'(T_GREEN2);
  localparam logic [5:0] D_YELLOW  = 6'(T_YELLOW);
  localparam logic [5:0] D_ALLRED  = 6'(T_ALLRED);
  localparam logic [5:0] D_WALK    = 6'(T_WALK);
  localparam logic [5:0] D_PED_CUT = 6'(T_PED_CUT);

  state_t     state;
  logic [5:0] timer;
  logic       ped_pend;
  logic       flash_ph;
  logic       walk;

  state_t     state_nxt;
  logic [5:0] dur_nxt;
  logic [5:0] ar_dur;
  logic       flash_entry;
  logic       ar_entry;
  logic       pend_next;

  assign ar_dur = ped_pend ? D_WALK : D_ALLRED;

  always_comb begin
    state_nxt = G1;
    dur_nxt   = D_GREEN1;
    case (state)
      G1:      begin state_nxt = Y1;  dur_nxt = D_YELLOW; end
      Y1:      begin state_nxt = AR1; dur_nxt = ar_dur;   end
      AR1:     begin state_nxt = G2;  dur_nxt = D_GREEN2; end
      G2:      begin state_nxt = Y2;  dur_nxt = D_YELLOW; end
      Y2:      begin state_nxt = AR2; dur_nxt = ar_dur;   end
      default: begin state_nxt = G1;  dur_nxt = D_GREEN1; end
    endcase
  end

  // A request landing on the same edge as an AR entry is kept for the next cycle;
  // entering FLASH discards everything.
  always_comb begin
    flash_entry = tick && night && (state != FLASH);
    ar_entry    = tick && !night && (state != FLASH) && (timer == 6'd1) &&
                  ((state == Y1) || (state == Y2));
    pend_next   = ped_pend;
    if (flash_entry || ar_entry) pend_next = 1'b0;
    if (ped_req && (state != FLASH) && !flash_entry) pend_next = 1'b1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= G1;
      timer    <= D_GREEN1;
      ped_pend <= 1'b0;
      flash_ph <= 1'b0;
      walk     <= 1'b0;
    end else begin
      if (tick) begin
        if (flash_entry) begin
          state    <= FLASH;
          timer    <= 6'd0;
          flash_ph <= 1'b0;
          walk     <= 1'b0;
        end else if (state == FLASH) begin
          if (!night) begin
            state <= AR2;
            timer <= D_ALLRED;
            walk  <= 1'b0;
          end else begin
            flash_ph <= ~flash_ph;
          end
        end else if (timer == 6'd1) begin
          state <= state_nxt;
          timer <= dur_nxt;
          if ((state_nxt == AR1) || (state_nxt == AR2)) walk <= ped_pend;
        end else if (((state == G1) || (state == G2)) && ped_pend && (timer > D_PED_CUT)) begin
          timer <= D_PED_CUT;
        end else begin
          timer <= timer - 6'd1;
        end
      end
      ped_pend <= pend_next;
    end
  end

  // Red-road counts give the time until that road turns green.
  always_comb begin
    LEDS     = 6'b100100;
    cnt_r1   = timer;
    cnt_r2   = timer;
    ped_walk = 1'b0;
    case (state)
      G1: begin
        LEDS   = 6'b001100;
        cnt_r2 = timer + D_YELLOW + ar_dur;
      end
      Y1: begin
        LEDS   = 6'b010100;
        cnt_r2 = timer + ar_dur;
      end
      AR1, AR2: begin
        LEDS     = 6'b100100;
        ped_walk = walk;
      end
      G2: begin
        LEDS   = 6'b100001;
        cnt_r1 = timer + D_YELLOW + ar_dur;
      end
      Y2: begin
        LEDS   = 6'b100010;
        cnt_r1 = timer + ar_dur;
      end
      default: begin
        LEDS   = {1'b0, flash_ph, 2'b00, flash_ph, 1'b0};
        cnt_r1 = 6'd0;
        cnt_r2 = 6'd0;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a reference model predicts each cycle's
// outputs into a queue, and a monitor pops and compares one entry per clock.
module tb_phase_sequencer;

  localparam int T_GREEN1  = 25;
  localparam int T_GREEN2  = 20;
  localparam int T_YELLOW  = 3;
  localparam int T_ALLRED  = 1;
  localparam int T_WALK    = 8;
  localparam int T_PED_CUT = 5;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tick    = 1'b0;
  logic       ped_req = 1'b0;
  logic       night   = 1'b0;
  logic [5:0] LEDS, cnt_r1, cnt_r2;
  logic       ped_walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_50M = ~clk_50M;

  phase_sequencer #(
    .T_GREEN1(T_GREEN1), .T_GREEN2(T_GREEN2), .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .T_PED_CUT(T_PED_CUT)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .tick    (tick),
    .ped_req (ped_req),
    .night   (night),
    .LEDS    (LEDS),
    .cnt_r1  (cnt_r1),
    .cnt_r2  (cnt_r2),
    .ped_walk(ped_walk),
    .phase   (phase)
  );

  // Reference model: phase index 0..5 around the ring, 6 = flashing.
  int   m_state, m_timer;
  bit   m_pend, m_fph, m_walk;
  logic [5:0]  lamp_tab [6] = '{6'b001100, 6'b010100, 6'b100100, 6'b100001, 6'b100010, 6'b100100};
  logic [21:0] exp_q [$];

  function automatic bit is_ar(int s);
    return (s == 2) || (s == 5);
  endfunction

  function automatic int dur(int s, bit pend);
    int base [6] = '{T_GREEN1, T_YELLOW, T_ALLRED, T_GREEN2, T_YELLOW, T_ALLRED};
    if (is_ar(s) && pend) return T_WALK;
    return base[s];
  endfunction

  function automatic void model_reset();
    m_state = 0; m_timer = T_GREEN1; m_pend = 0; m_fph = 0; m_walk = 0;
  endfunction

  function automatic void model_step(bit t, bit p, bit n);
    int s0 = m_state;
    bit pend0 = m_pend;
    bit to_flash = 0;
    if (t) begin
      if (s0 != 6 && n) begin
        m_state = 6; m_fph = 0; m_pend = 0; m_walk = 0; to_flash = 1;
      end else if (s0 == 6) begin
        if (!n) begin m_state = 5; m_timer = T_ALLRED; m_walk = 0; end
        else m_fph = !m_fph;
      end else if (m_timer == 1) begin
        m_state = (s0 + 1) % 6;
        m_timer = dur(m_state, pend0);
        if (is_ar(m_state)) begin m_walk = pend0; m_pend = 0; end
      end else if ((s0 == 0 || s0 == 3) && pend0 && m_timer > T_PED_CUT) begin
        m_timer = T_PED_CUT;
      end else begin
        m_timer = m_timer - 1;
      end
    end
    if (p && s0 != 6 && !to_flash) m_pend = 1;
  endfunction

  // Red road waits out the rest of this phase plus every phase up to the next all-red.
  function automatic logic [21:0] model_out();
    logic [5:0] leds, c1, c2;
    bit w;
    int other, k;
    w = 0;
    if (m_state == 6) begin
      leds = m_fph ? 6'b010010 : 6'b000000;
      c1 = 0; c2 = 0;
    end else begin
      leds = lamp_tab[m_state];
      if (is_ar(m_state)) begin
        c1 = 6'(m_timer); c2 = 6'(m_timer); w = m_walk;
      end else begin
        other = m_timer;
        k = m_state;
        do begin
          k = (k + 1) % 6;
          other += dur(k, m_pend);
        end while (!is_ar(k));
        if (m_state < 3) begin c1 = 6'(m_timer); c2 = 6'(other); end
        else begin c2 = 6'(m_timer); c1 = 6'(other); end
      end
    end
    return {leds, c1, c2, w, 3'(m_state)};
  endfunction

  task automatic check_vec(input string name, input logic [21:0] exp);
    logic [21:0] act;
    act = {LEDS, cnt_r1, cnt_r2, ped_walk, phase};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got leds=%b c1=%0d c2=%0d walk=%b phase=%0d, expected leds=%b c1=%0d c2=%0d walk=%b phase=%0d",
               name, $time, act[21:16], act[15:10], act[9:4], act[3], act[2:0],
               exp[21:16], exp[15:10], exp[9:4], exp[3], exp[2:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one prediction per clock, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk_50M);
      #1;
      if (exp_q.size() > 0) check_vec("scoreboard", exp_q.pop_front());
    end
  end

  task automatic cycle(input bit t, input bit p, input bit n);
    tick = t; ped_req = p; night = n;
    if (!rst_n) model_reset();
    else model_step(t, p, n);
    exp_q.push_back(model_out());
    @(negedge clk_50M);
  endtask

  task automatic tick_n(input int k, input bit n);
    for (int i = 0; i < k; i++) begin
      cycle(1'b1, 1'b0, n);
      cycle(1'b0, 1'b0, n);
    end
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit nite;
    model_reset();

    // Default ring, full-period walk with spot values from the countdown rules.
    reset_seq();
    check_val("reset_cnt_r1", cnt_r1, 25);
    check_val("reset_cnt_r2", cnt_r2, 29);
    check_val("reset_leds", LEDS, 6'b001100);
    tick_n(24, 1'b0);
    check_val("g1_end_cnt_r1", cnt_r1, 1);
    check_val("g1_end_cnt_r2", cnt_r2, 5);
    tick_n(1, 1'b0);
    check_val("y1_phase", phase, 1);
    check_val("y1_cnt_r1", cnt_r1, 3);
    check_val("y1_cnt_r2", cnt_r2, 4);
    tick_n(37, 1'b0);
    $display("scenario ring: 62 ticks, phase=%0d", phase);

    // Pedestrian request mid-green.
    reset_seq();
    tick_n(5, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("ped_cnt_r2_jump", cnt_r2, 31);
    tick_n(1, 1'b0);
    check_val("ped_trunc_timer", cnt_r1, 5);
    tick_n(5, 1'b0);
    check_val("ped_y1_phase", phase, 1);
    tick_n(3, 1'b0);
    check_val("ped_ar1_walk", ped_walk, 1);
    tick_n(7, 1'b0);
    check_val("ped_ar1_still", phase, 2);
    tick_n(1, 1'b0);
    check_val("ped_g2_phase", phase, 3);
    check_val("ped_g2_walk", ped_walk, 0);
    $display("scenario ped: walk interval served");

    // Request on the same edge as a tick: no truncation on that tick.
    reset_seq();
    tick_n(15, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("coinc_timer9", cnt_r1, 9);
    tick_n(1, 1'b0);
    check_val("coinc_timer5", cnt_r1, 5);
    $display("scenario coincident ped: done");

    // Night mode entered from Y2.
    reset_seq();
    tick_n(49, 1'b0);
    check_val("night_pre_y2", phase, 4);
    tick_n(1, 1'b1);
    check_val("flash_phase", phase, 6);
    check_val("flash_leds0", LEDS, 6'b000000);
    tick_n(1, 1'b1);
    check_val("flash_leds1", LEDS, 6'b010010);
    check_val("flash_cnt", cnt_r1 + cnt_r2, 0);
    tick_n(1, 1'b1);
    check_val("flash_leds2", LEDS, 6'b000000);
    tick_n(1, 1'b0);
    check_val("flash_exit_ar2", phase, 5);
    tick_n(1, 1'b0);
    check_val("flash_exit_g1", phase, 0);
    check_val("flash_exit_timer", cnt_r1, 25);
    $display("scenario night: flash and exit");

    // Asynchronous reset mid-G2 with tick held high.
    reset_seq();
    tick_n(35, 1'b0);
    tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_vec("async_reset", model_out());
    exp_q.push_back(model_out());
    @(negedge clk_50M);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check_val("post_reset_cnt_r2", cnt_r2, 29);
    $display("scenario async reset: done");

    // Randomised traffic with pedestrian pulses and night windows.
    reset_seq();
    nite = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) nite = !nite;
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, nite);
    end
    cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk_50M);
    #2;
    check_val("queue_drained", exp_q.size(), 0);
    $display("scenario random: 4000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Intersection phase controller for the two-road traffic light.
- Sequences the green, yellow and all-red phases of road 1 and road 2.
- Produces the six lamp LEDs and the per-road seconds-remaining values. These values feed the sep2/display digit path in place of the free-running subtract counter.
- Adds a pedestrian request that shortens green and inserts a walk interval, plus a night flashing-yellow mode.
- Runs on clk_50M and advances only on a one-cycle 1 s tick enable from the clock divider.

Parameters:
- T_GREEN1, 25, road 1 green duration in ticks (1..63).
- T_GREEN2, 20, road 2 green duration in ticks (1..63).
- T_YELLOW, 3, yellow duration in ticks (1..63).
- T_ALLRED, 1, all-red clearance duration in ticks (1..63).
- T_WALK, 8, all-red duration when a pedestrian request is served (1..63).
- T_PED_CUT, 5, remaining green after a pedestrian truncation (1..63).
- Constraint: max(T_ALLRED,T_WALK)+T_YELLOW+max(T_GREEN1,T_GREEN2) ≤ 63.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  1 s enable; one clk_50M cycle high per second.
- ped_req  in  1  pedestrian button pulse, synchronous to clk_50M.
- night  in  1  night-mode level, synchronous to clk_50M.
- LEDS  out  6  {r1_red, r1_yel, r1_grn, r2_red, r2_yel, r2_grn}.
- cnt_r1  out  6  seconds remaining for road 1's current colour.
- cnt_r2  out  6  seconds remaining for road 2's current colour.
- ped_walk  out  1  walk lamp.
- phase  out  3  encoded state, for debug and bench.

Behaviour:
- States and encoding: G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5, FLASH=6.
- Normal sequence: G1→Y1→AR1→G2→Y2→AR2→G1.
- Registers:
  - state.
  - timer[5:0].
  - ped_pend.
  - flash_ph: toggles each tick while in FLASH.
- All outputs decode combinationally from these registers. There is no extra latency: outputs change in the cycle after the clock edge on which tick=1.
- Reset (async, rst_n=0):
  - state=G1, timer=T_GREEN1, ped_pend=0, flash_ph=0.
  - LEDS=6'b001100, cnt_r1=25, cnt_r2=29, ped_walk=0, phase=0.
- Timer:
  - On entry to a state, timer loads that state's duration.
  - On each tick, if timer==1 the block moves to the next state and loads the next duration; otherwise timer decrements.
  - Each state therefore lasts exactly its duration in ticks.
  - No register changes when tick=0, except ped_pend capture.
- AR1/AR2 duration: T_WALK if ped_pend=1 at entry, else T_ALLRED.
  - ped_pend clears on the clock edge that enters AR1 or AR2.
  - ped_walk=1 while in an AR state entered with ped_pend=1. This is held by a one-bit walk flag set on entry.
- ped_pend capture:
  - Set on any cycle with ped_req=1 and state≠FLASH.
  - Simultaneous with a tick: the tick uses the old ped_pend value, and the new request is captured.
  - Repeated requests while pending have no effect.
- Truncation: in G1 or G2, on a tick with ped_pend=1 and timer>T_PED_CUT, timer loads T_PED_CUT instead of decrementing. Truncation is not applied in any other state.
- Lamps:
  - G1: r1_grn, r2_red.
  - Y1: r1_yel, r2_red.
  - AR1/AR2: both red.
  - G2: r2_grn, r1_red.
  - Y2: r2_yel, r1_red.
  - FLASH: r1_yel=r2_yel=flash_ph, all others 0.
- Countdown for the green/yellow road: equals timer.
- Countdown for the red road (time until its green):
  - In G1, cnt_r2 = timer+T_YELLOW+ARdur.
  - In Y1, cnt_r2 = timer+ARdur.
  - In AR1, cnt_r2 = timer.
  - G2/Y2/AR2 are symmetric for cnt_r1.
  - In AR2, cnt_r1 = timer. In AR1, cnt_r1 = timer+T_GREEN2+T_YELLOW+T_ALLRED-style values are not shown; cnt_r1 = timer in both AR states.
  - ARdur is T_WALK when ped_pend=1, else T_ALLRED. A request arriving mid-green therefore makes the red-road count jump; this is intended.
- FLASH mode:
  - Entry: night is sampled only on ticks. On a tick with night=1 in any non-FLASH state, go to FLASH. This overrides the timer and truncation. It clears ped_pend and flash_ph, and sets cnt_r1=cnt_r2=0.
  - Exit: on a tick in FLASH with night=0, go to AR2 with timer=T_ALLRED, so G1 follows.
- Async reset mid-operation returns to the reset values immediately, regardless of tick.

Test Plan:
- Reset release, 62 ticks with defaults → phase sequence G1(25)/Y1(3)/AR1(1)/G2(20)/Y2(3)/AR2(1); 53-tick period; LEDS 001100→010100→100100→100001→100010→100100.
- Immediately after reset: cnt_r1=25, cnt_r2=29. After 24 ticks: cnt_r1=1, cnt_r2=5. Next tick: Y1, cnt_r1=3, cnt_r2=4.
- ped_req pulse at G1 with timer=20:
  - cnt_r2 jumps to 31.
  - Next tick: timer=5.
  - After 5 more ticks: Y1.
  - AR1 lasts 8 ticks with ped_walk=1.
  - ped_walk=0 in G2.
- ped_req coincident with the tick where the G1 timer goes 10→9: no truncation on that tick (timer=9); next tick gives timer=5.
- night=1 asserted during Y2:
  - Next tick: FLASH, LEDS=000000.
  - Then 010010 and 000000 alternate each tick; cnt=0.
  - night=0 → AR2 for 1 tick, then G1 with timer=25.
- rst_n low for 3 cycles mid-G2 with tick high → state G1, timer=25, ped_pend=0 asynchronously; outputs at reset values.
